// File: rtl/pwm_frame_loader.sv
// Byte-stream loader for PwmCtrl: parses HEADER-framed phase/amp updates into a shadow bank
// and commits them to the active arrays on the PWM start pulse. Optional checksum: PWM_LOADER_CHECKSUM_EN.
module pwm_frame_loader #(
  parameter int         NUM_CHANNELS = 16,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       start,
  output logic [7:0] phase [NUM_CHANNELS],
  output logic [6:0] amp   [NUM_CHANNELS],
  output logic       pending,
  output logic       swapped,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

`ifdef PWM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_HUNT, S_PHASE, S_AMP, S_CSUM} state_t;
  logic [7:0] r_csum;
`else
  typedef enum logic [1:0] {S_HUNT, S_PHASE, S_AMP} state_t;
`endif

  state_t        r_state;
  logic [CW-1:0] r_ch;
  logic [7:0]    r_phase    [NUM_CHANNELS];
  logic [6:0]    r_amp      [NUM_CHANNELS];
  logic [7:0]    r_sh_phase [NUM_CHANNELS];
  logic [6:0]    r_sh_amp   [NUM_CHANNELS];
  logic          r_pending;
  logic          r_swapped;
  logic          r_frame_ok;
  logic          r_frame_err;
  logic          w_accept;

  // Stalling while a committed frame waits keeps the shadow bank stable until swap.
  assign in_ready  = !reset && !r_pending;
  assign w_accept  = in_valid && in_ready;
  assign pending   = r_pending;
  assign swapped   = r_swapped;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_out
      assign phase[gi] = r_phase[gi];
      assign amp[gi]   = r_amp[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_HUNT;
      r_ch        <= '0;
      r_pending   <= 1'b0;
      r_swapped   <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef PWM_LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_phase[i]    <= '0;
        r_amp[i]      <= '0;
        r_sh_phase[i] <= '0;
        r_sh_amp[i]   <= '0;
      end
    end else begin
      r_swapped   <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;

      // Swap and commit are exclusive: commit needs an accepted byte, which needs pending==0.
      if (start && r_pending) begin
        r_phase   <= r_sh_phase;
        r_amp     <= r_sh_amp;
        r_pending <= 1'b0;
        r_swapped <= 1'b1;
      end

      if (w_accept) begin
        case (r_state)
          S_HUNT: begin
            if (in_data == HEADER) begin
              r_state <= S_PHASE;
              r_ch    <= '0;
`ifdef PWM_LOADER_CHECKSUM_EN
              r_csum  <= '0;
`endif
            end
          end
          S_PHASE: begin
            r_sh_phase[r_ch] <= in_data;
`ifdef PWM_LOADER_CHECKSUM_EN
            r_csum           <= r_csum ^ in_data;
`endif
            r_state          <= S_AMP;
          end
          S_AMP: begin
            if (in_data[7]) begin
              r_frame_err <= 1'b1;
              r_state     <= S_HUNT;
            end else begin
              r_sh_amp[r_ch] <= in_data[6:0];
`ifdef PWM_LOADER_CHECKSUM_EN
              r_csum         <= r_csum ^ in_data;
`endif
              if (r_ch == LAST_CH) begin
`ifdef PWM_LOADER_CHECKSUM_EN
                r_state    <= S_CSUM;
`else
                r_frame_ok <= 1'b1;
                r_pending  <= 1'b1;
                r_state    <= S_HUNT;
`endif
              end else begin
                r_ch    <= r_ch + 1'b1;
                r_state <= S_PHASE;
              end
            end
          end
`ifdef PWM_LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (in_data == r_csum) begin
              r_frame_ok <= 1'b1;
              r_pending  <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= S_HUNT;
          end
`endif
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_frame_loader.sv
// Scoreboard bench for pwm_frame_loader: expected pulses are queued as frames/starts are driven
// and matched against frame_ok/frame_err/swapped as they appear.
module tb_pwm_frame_loader;

  localparam int         N   = 16;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int K_OK = 1, K_ERR = 2, K_SWAP = 3;

  typedef struct {
    int           kind;
    logic [127:0] ph;
    logic [111:0] am;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       start;
  logic [7:0] phase [N];
  logic [6:0] amp   [N];
  logic       pending;
  logic       swapped;
  logic       frame_ok;
  logic       frame_err;

  ev_t          sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] dut_ph;
  logic [111:0] dut_am;
  logic [127:0] pa_ph, pb_ph, pc_ph, pd_ph;
  logic [111:0] pa_am, pb_am, pc_am, pd_am;

  pwm_frame_loader #(.NUM_CHANNELS(N), .HEADER(HDR)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .phase(phase), .amp(amp), .pending(pending), .swapped(swapped),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_ph = '0;
    dut_am = '0;
    for (int i = 0; i < N; i++) begin
      dut_ph[i*8 +: 8] = phase[i];
      dut_am[i*7 +: 7] = amp[i];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic push(input int kind, input logic [127:0] ph, input logic [111:0] am);
    ev_t e;
    e.kind = kind;
    e.ph   = ph;
    e.am   = am;
    sb.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event", kind, 0);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == K_SWAP && e.kind == K_SWAP) begin
      chk("swap_phase", dut_ph, e.ph);
      chk("swap_amp", dut_am, e.am);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_ok)  take(K_OK);
      if (frame_err) take(K_ERR);
      if (swapped)   take(K_SWAP);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_start);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) chk("ready_timeout", 0, 1);
    start = with_start;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // mode 0: good frame, 1: corrupted checksum, 2: amp 8'h80 on channel 3
  task automatic send_frame(input logic [127:0] ph, input logic [111:0] am, input int mode,
                            input bit start_last);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send_byte(HDR, 1'b0);
    for (int i = 0; i < N; i++) begin
      b = ph[i*8 +: 8];
      cs ^= b;
      send_byte(b, 1'b0);
      b = {1'b0, am[i*7 +: 7]};
      if (mode == 2 && i == 3) begin
        push(K_ERR, '0, '0);
        send_byte(8'h80, 1'b0);
        return;
      end
      cs ^= b;
`ifdef PWM_LOADER_CHECKSUM_EN
      send_byte(b, 1'b0);
`else
      if (i == N - 1) begin
        push(K_OK, '0, '0);
        send_byte(b, start_last);
      end else begin
        send_byte(b, 1'b0);
      end
`endif
    end
`ifdef PWM_LOADER_CHECKSUM_EN
    if (mode == 1) begin
      push(K_ERR, '0, '0);
      cs ^= 8'h01;
    end else begin
      push(K_OK, '0, '0);
    end
    send_byte(cs, start_last);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    idle(2);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; in_data = '0; in_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < N; i++) begin
      pa_ph[i*8 +: 8] = 8'(16 * i);
      pa_am[i*7 +: 7] = 7'(124 - 8 * i);
      pb_ph[i*8 +: 8] = 8'(255 - 3 * i);
      pb_am[i*7 +: 7] = 7'(5 * i + 1);
      pc_ph[i*8 +: 8] = 8'(7 * i + 3);
      pc_am[i*7 +: 7] = 7'(127 - i);
      pd_ph[i*8 +: 8] = 8'($urandom_range(0, 255));
      pd_am[i*7 +: 7] = 7'($urandom_range(0, 127));
    end

    idle(3);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pending", pending, 0);
    chk("rst_phase", dut_ph, 0);
    chk("rst_amp", dut_am, 0);
    chk("rst_pulses", {frame_ok, frame_err, swapped}, 0);
    reset = 1'b0;
    idle(1);
    chk("in_ready_after_rst", in_ready, 1);

    // Idle starts must not swap anything
    pulse_start();
    pulse_start();
    chk("idle_phase", dut_ph, 0);
    chk("idle_amp", dut_am, 0);

    // Good frame A, then swap
    send_frame(pa_ph, pa_am, 0, 1'b0);
    idle(1);
    chk("a_pending", pending, 1);
    chk("a_in_ready", in_ready, 0);
    chk("a_phase_held", dut_ph, 0);
    push(K_SWAP, pa_ph, pa_am);
    pulse_start();
    chk("a_pending_clr", pending, 0);
    chk("a_phase", dut_ph, pa_ph);

`ifdef PWM_LOADER_CHECKSUM_EN
    send_frame(pb_ph, pb_am, 1, 1'b0);
    idle(2);
    chk("badcs_pending", pending, 0);
    pulse_start();
    chk("badcs_phase", dut_ph, pa_ph);
    chk("badcs_amp", dut_am, pa_am);
`endif

    // Bad amp byte on channel 3
    send_frame(pc_ph, pc_am, 2, 1'b0);
    idle(2);
    chk("badamp_pending", pending, 0);
    chk("badamp_in_ready", in_ready, 1);
    pulse_start();
    chk("badamp_phase", dut_ph, pa_ph);
    chk("badamp_amp", dut_am, pa_am);

    // Garbage before header, then frame B commits
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_frame(pb_ph, pb_am, 0, 1'b0);
    idle(2);
    chk("b_pending", pending, 1);

    // Frame C streamed while B is pending: stalls until the swap
    push(K_SWAP, pb_ph, pb_am);
    fork
      send_frame(pc_ph, pc_am, 0, 1'b0);
      begin
        idle(20);
        chk("stall_in_ready", in_ready, 0);
        pulse_start();
      end
    join
    idle(2);
    chk("c_pending", pending, 1);
    chk("c_phase_is_b", dut_ph, pb_ph);
    push(K_SWAP, pc_ph, pc_am);
    pulse_start();

    // Frame D with start on the final byte: swap deferred to the next start
    send_frame(pd_ph, pd_am, 0, 1'b1);
    idle(3);
    chk("d_pending", pending, 1);
    chk("d_phase_deferred", dut_ph, pc_ph);
    push(K_SWAP, pd_ph, pd_am);
    pulse_start();
    chk("d_amp", dut_am, pd_am);

    // Reset while a frame is pending
    send_frame(pa_ph, pa_am, 0, 1'b0);
    idle(3);
    chk("sb_drained", sb.size(), 0);
    reset = 1'b1;
    #1;
    chk("midrst_phase", dut_ph, 0);
    chk("midrst_amp", dut_am, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_in_ready", in_ready, 0);
    idle(2);
    reset = 1'b0;
    idle(2);
    chk("post_rst_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
